// File: rtl/user_regs_axil.sv
// AXI4-Lite user register block: ID, LED, SCRATCH, free-running CYCLES.
// Optional HB_DIV heartbeat on led[3] when USER_REGS_HEARTBEAT_EN is defined.
module user_regs_axil #(
  parameter logic [31:0] ID_VALUE = 32'hA7C1_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [5:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [3:0]  led
);

  localparam logic [3:0] IDX_ID  = 4'd0;
  localparam logic [3:0] IDX_LED = 4'd1;
  localparam logic [3:0] IDX_SCR = 4'd2;
  localparam logic [3:0] IDX_CYC = 4'd3;
  localparam logic [3:0] IDX_HB  = 4'd4;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        up;
  logic        aw_held;
  logic        w_held;
  logic [3:0]  aw_idx;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [3:0]  led_q;
  logic [31:0] scratch;
  logic [31:0] cycles;

  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        commit;
  logic        wr_err;
  logic        rd_err;
  logic [31:0] rd_data;
  logic        unused_ok;

`ifdef USER_REGS_HEARTBEAT_EN
  logic [31:0] hb_div;
  logic [31:0] hb_cnt;
  logic        hb_led;
`endif

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] din,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = strb[i] ? din[8*i +: 8] : old[8*i +: 8];
    return res;
  endfunction

  // readies stay low until the first edge after reset releases
  assign s_axi_awready = up & ~aw_held & ~s_axi_bvalid;
  assign s_axi_wready  = up & ~w_held & ~s_axi_bvalid;
  assign s_axi_arready = up & ~s_axi_rvalid;

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign commit = aw_held & w_held;

  assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  always_comb begin
    wr_err = 1'b0;
    case (aw_idx)
      IDX_ID, IDX_LED, IDX_SCR, IDX_CYC: wr_err = 1'b0;
`ifdef USER_REGS_HEARTBEAT_EN
      IDX_HB: wr_err = 1'b0;
`endif
      default: wr_err = 1'b1;
    endcase
  end

  always_comb begin
    rd_data = 32'h0;
    rd_err  = 1'b0;
    case (s_axi_araddr[5:2])
      IDX_ID:  rd_data = ID_VALUE;
      IDX_LED: rd_data = {28'h0, led_q};
      IDX_SCR: rd_data = scratch;
      IDX_CYC: rd_data = cycles;
`ifdef USER_REGS_HEARTBEAT_EN
      IDX_HB:  rd_data = hb_div;
`endif
      default: rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up           <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= 4'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      led_q        <= 4'h0;
      scratch      <= 32'h0;
      cycles       <= 32'h0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= OKAY;
      s_axi_rdata  <= 32'h0;
`ifdef USER_REGS_HEARTBEAT_EN
      hb_div       <= 32'h0;
`endif
    end else begin
      up     <= 1'b1;
      cycles <= cycles + 32'd1;

      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi_awaddr[5:2];
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end

      if (s_axi_bvalid && s_axi_bready)
        s_axi_bvalid <= 1'b0;

      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_err ? SLVERR : OKAY;
        case (aw_idx)
          IDX_LED: if (wstrb_q[0]) led_q <= wdata_q[3:0];
          IDX_SCR: scratch <= merge(scratch, wdata_q, wstrb_q);
`ifdef USER_REGS_HEARTBEAT_EN
          IDX_HB:  hb_div <= merge(hb_div, wdata_q, wstrb_q);
`endif
          default: ;
        endcase
      end

      // read mux sees pre-write state in a commit cycle
      if (ar_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_err ? SLVERR : OKAY;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

`ifdef USER_REGS_HEARTBEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hb_cnt <= 32'h0;
      hb_led <= 1'b0;
    end else if (hb_div == 32'h0) begin
      hb_cnt <= 32'h0;
      hb_led <= 1'b0;
    end else if (hb_cnt >= hb_div) begin
      hb_cnt <= 32'h0;
      hb_led <= ~hb_led;
    end else begin
      hb_cnt <= hb_cnt + 32'd1;
    end
  end

  assign led = {(hb_div != 32'h0) ? hb_led : led_q[3], led_q[2:0]};
`else
  assign led = led_q;
`endif

endmodule

// File: tb/tb_user_regs_axil.sv
// Directed bench for user_regs_axil: reset, decode, strobes, backpressure,
// CYCLES, unmapped access, same-cycle read/write, reset mid-transaction.
module tb_user_regs_axil;

  logic        clk;
  logic        reset;
  logic [5:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [5:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [3:0]  led;

  int total = 0;
  int bad = 0;

  user_regs_axil dut (
    .clk(clk),
    .reset(reset),
    .s_axi_awaddr(awaddr),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bresp(bresp),
    .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_araddr(araddr),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata(rdata),
    .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid),
    .s_axi_rready(rready),
    .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic axi_write(
    input  logic [5:0]  a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    output logic [1:0]  resp,
    output bit          ok
  );
    bit aw_hs;
    bit w_hs;
    int n;
    awaddr = a;
    wdata = d;
    wstrb = s;
    awvalid = 1'b1;
    wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      @(posedge clk);
      #1;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
      n++;
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = bvalid;
    resp = bresp;
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(
    input  logic [5:0]  a,
    output logic [31:0] d,
    output logic [1:0]  resp,
    output bit          ok
  );
    bit hs;
    int n;
    araddr = a;
    arvalid = 1'b1;
    hs = 1'b0;
    n = 0;
    while (!hs && n < 20) begin
      hs = arready;
      @(posedge clk);
      #1;
      n++;
    end
    arvalid = 1'b0;
    ok = hs && rvalid;
    d = rdata;
    resp = rresp;
    rready = 1'b1;
    @(posedge clk);
    #1;
    rready = 1'b0;
  endtask

  task automatic test_reset;
    total++;
    if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got aw=%b w=%b ar=%b want 000",
               awready, wready, arready);
    end
    total++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || led !== 4'h0 ||
        rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outs got bv=%b rv=%b led=%h rdata=%h want 0",
               bvalid, rvalid, led, rdata);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin
      bad++;
      $display("FAIL release_ready got aw=%b w=%b ar=%b want 111",
               awready, wready, arready);
    end
  endtask

  task automatic test_id_read;
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    axi_read(6'h00, d, r, ok);
    total++;
    if (!ok || d !== 32'hA7C1_0001 || r !== 2'b00) begin
      bad++;
      $display("FAIL id_read got ok=%0d d=%h r=%b want d=a7c10001 r=00",
               ok, d, r);
    end
  endtask

  task automatic test_strobe_split;
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    int n;
    awaddr = 6'h08;
    awvalid = 1'b1;
    total++;
    if (awready !== 1'b1) begin
      bad++;
      $display("FAIL split_awready got %b want 1", awready);
    end
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bvalid !== 1'b0 || wready !== 1'b1) begin
      bad++;
      $display("FAIL split_wait got bv=%b wr=%b want bv=0 wr=1",
               bvalid, wready);
    end
    wdata = 32'h1234_5678;
    wstrb = 4'b0101;
    wvalid = 1'b1;
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      bad++;
      $display("FAIL split_bresp got bv=%b r=%b want bv=1 r=00",
               bvalid, bresp);
    end
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
    axi_read(6'h08, d, r, ok);
    total++;
    if (!ok || d !== 32'h0034_0078 || r !== 2'b00) begin
      bad++;
      $display("FAIL split_scratch got d=%h r=%b want 00340078 00", d, r);
    end
  endtask

  task automatic test_led_backpressure;
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    int n;
    int stuck;
    awaddr = 6'h04;
    wdata = 32'h0000_000A;
    wstrb = 4'hF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (bvalid !== 1'b1 || led !== 4'b1010) begin
      bad++;
      $display("FAIL led_commit got bv=%b led=%b want bv=1 led=1010",
               bvalid, led);
    end
    stuck = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 ||
          wready !== 1'b0)
        stuck++;
    end
    total++;
    if (stuck != 0) begin
      bad++;
      $display("FAIL led_hold got %0d bad cycles want 0", stuck);
    end
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
    total++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      bad++;
      $display("FAIL led_release got bv=%b aw=%b want bv=0 aw=1",
               bvalid, awready);
    end
    axi_read(6'h04, d, r, ok);
    total++;
    if (!ok || d !== 32'h0000_000A) begin
      bad++;
      $display("FAIL led_read got %h want 0000000a", d);
    end
  endtask

  task automatic test_ro_and_zero_strb;
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    axi_write(6'h00, 32'hFFFF_FFFF, 4'hF, r, ok);
    total++;
    if (!ok || r !== 2'b00) begin
      bad++;
      $display("FAIL ro_bresp got ok=%0d r=%b want 00", ok, r);
    end
    axi_read(6'h00, d, r, ok);
    total++;
    if (!ok || d !== 32'hA7C1_0001) begin
      bad++;
      $display("FAIL ro_keep got %h want a7c10001", d);
    end
    axi_write(6'h08, 32'hFFFF_FFFF, 4'h0, r, ok);
    total++;
    if (!ok || r !== 2'b00) begin
      bad++;
      $display("FAIL strb0_bresp got ok=%0d r=%b want 00", ok, r);
    end
    axi_read(6'h0B, d, r, ok);
    total++;
    if (!ok || d !== 32'h0034_0078) begin
      bad++;
      $display("FAIL strb0_keep got %h want 00340078", d);
    end
  endtask

  task automatic test_cycles;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0] r;
    bit ok0;
    bit ok1;
    axi_read(6'h0C, d0, r, ok0);
    repeat (8) @(posedge clk);
    #1;
    axi_read(6'h0C, d1, r, ok1);
    total++;
    if (!ok0 || !ok1 || (d1 - d0) !== 32'd10) begin
      bad++;
      $display("FAIL cycles_diff got %0d want 10", d1 - d0);
    end
    force dut.cycles = 32'hFFFF_FFFE;
    #1;
    release dut.cycles;
    axi_read(6'h0C, d0, r, ok0);
    axi_read(6'h0C, d1, r, ok1);
    total++;
    if (!ok0 || d0 !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL cycles_pre got %h want fffffffe", d0);
    end
    total++;
    if (!ok1 || d1 !== 32'h0) begin
      bad++;
      $display("FAIL cycles_wrap got %h want 00000000", d1);
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    axi_write(6'h14, 32'hDEAD_BEEF, 4'hF, r, ok);
    total++;
    if (!ok || r !== 2'b10) begin
      bad++;
      $display("FAIL unm_bresp got ok=%0d r=%b want 10", ok, r);
    end
    axi_read(6'h14, d, r, ok);
    total++;
    if (!ok || d !== 32'h0 || r !== 2'b10) begin
      bad++;
      $display("FAIL unm_read got d=%h r=%b want 0 10", d, r);
    end
    axi_read(6'h08, d, r, ok);
    total++;
    if (!ok || d !== 32'h0034_0078 || led !== 4'b1010) begin
      bad++;
      $display("FAIL unm_nochange got scr=%h led=%b want 00340078 1010",
               d, led);
    end
  endtask

  task automatic test_hb;
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
`ifdef USER_REGS_HEARTBEAT_EN
    logic s [16];
    int errs;
    axi_write(6'h10, 32'd3, 4'hF, r, ok);
    total++;
    if (!ok || r !== 2'b00) begin
      bad++;
      $display("FAIL hb_bresp got r=%b want 00", r);
    end
    for (int i = 0; i < 16; i++) begin
      s[i] = led[3];
      @(posedge clk);
      #1;
    end
    errs = 0;
    for (int i = 0; i < 12; i++)
      if (s[i+4] === s[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL hb_period got %0d mismatched samples want 0", errs);
    end
    axi_write(6'h10, 32'd0, 4'hF, r, ok);
    total++;
    if (led !== 4'b1010) begin
      bad++;
      $display("FAIL hb_off got led=%b want 1010", led);
    end
`else
    axi_write(6'h10, 32'd3, 4'hF, r, ok);
    total++;
    if (!ok || r !== 2'b10) begin
      bad++;
      $display("FAIL hb_absent_w got r=%b want 10", r);
    end
    axi_read(6'h10, d, r, ok);
    total++;
    if (!ok || d !== 32'h0 || r !== 2'b10) begin
      bad++;
      $display("FAIL hb_absent_r got d=%h r=%b want 0 10", d, r);
    end
`endif
    d = 32'h0;
  endtask

  task automatic test_same_cycle;
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    awaddr = 6'h08;
    wdata = 32'hCAFE_F00D;
    wstrb = 4'hF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid = 1'b0;
    araddr = 6'h08;
    arvalid = 1'b1;
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    total++;
    if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== 32'h0034_0078) begin
      bad++;
      $display("FAIL same_cycle got rv=%b bv=%b d=%h want 1 1 00340078",
               rvalid, bvalid, rdata);
    end
    rready = 1'b1;
    bready = 1'b1;
    @(posedge clk);
    #1;
    rready = 1'b0;
    bready = 1'b0;
    axi_read(6'h08, d, r, ok);
    total++;
    if (!ok || d !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL same_after got %h want cafef00d", d);
    end
  endtask

  task automatic test_reset_midway;
    logic [31:0] d;
    logic [1:0] r;
    bit ok;
    int seen;
    awaddr = 6'h08;
    awvalid = 1'b1;
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bvalid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0 || awready !== 1'b1 || led !== 4'h0) begin
      bad++;
      $display("FAIL mid_reset got bv_cycles=%0d aw=%b led=%b want 0 1 0",
               seen, awready, led);
    end
    axi_write(6'h08, 32'h5A5A_0F0F, 4'hF, r, ok);
    axi_read(6'h08, d, r, ok);
    total++;
    if (!ok || d !== 32'h5A5A_0F0F) begin
      bad++;
      $display("FAIL mid_newwrite got %h want 5a5a0f0f", d);
    end
  endtask

  initial begin
    reset = 1'b1;
    awaddr = '0;
    awvalid = 1'b0;
    wdata = '0;
    wstrb = '0;
    wvalid = 1'b0;
    bready = 1'b0;
    araddr = '0;
    arvalid = 1'b0;
    rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_id_read;
    test_strobe_split;
    test_led_backpressure;
    test_ro_and_zero_strb;
    test_cycles;
    test_unmapped;
    test_hb;
    test_same_cycle;
    test_reset_midway;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
